// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Sequencing controller for a UART receive engine built around an external
// 10-bit right-shifting frame register (serial in at bit 9, one shift per
// sh pulse). This block:
//   - synchronizes the raw serial line,
//   - detects a falling edge and qualifies it as a start bit at mid-bit,
//   - times mid-bit samples for the 8 data bits and the stop bit,
//   - issues one sh pulse (with the sampled bit on sdi) per frame bit,
//   - unpacks the captured frame into data/rdy/ferr (and optionally ovr).
//
// Parameters:
//   BAUD_DIV  clocks per bit period (>= 4). Bit timer is $clog2(BAUD_DIV) wide.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   rx        in   raw serial line (asynchronous, idle high)
//   shiftout  in   [9:0] frame register contents fed back from the shifter
//   rd_ack    in   single-cycle consumer acknowledge; clears rdy (and ovr)
//   sh        out  registered one-clock shift-enable pulse to the frame register
//   sdi       out  registered sampled bit, valid while sh = 1
//   data      out  [7:0] received byte, held until the next frame completes
//   rdy       out  byte available, sticky until rd_ack
//   ferr      out  stop bit of the last frame was 0
//   ovr       out  overrun flag (only live with UART_RX_OVERRUN_EN defined)
//   busy      out  high in every state except IDLE
//
// Build option:
//   UART_RX_OVERRUN_EN  when defined, a frame completing while rdy is still
//                       set (and not acknowledged that cycle) sets the sticky
//                       ovr flag. When undefined, ovr is tied low.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [9:0] shiftout,
  input  logic       rd_ack,
  output logic       sh,
  output logic       sdi,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ferr,
  output logic       ovr,
  output logic       busy
);

  localparam int TW          = $clog2(BAUD_DIV);
  localparam int SYNC_STAGES = 2;

  // Half a bit (minus one for the cycle spent entering VERIFY) lands the
  // start-bit sample in the middle of the start bit; a full period from there
  // lands every later sample mid-bit as well.
  localparam logic [TW-1:0] HALF_LOAD  = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD  = TW'(BAUD_DIV - 1);
  localparam logic [3:0]    FRAME_BITS = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    VERIFY,
    SHIFT,
    SETTLE,
    DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer: a chain of flops, all reset to the idle (high) level so
  // a reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   rx_s;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = rx;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t          state_reg,   state_next;
  logic [TW-1:0]   timer_reg,   timer_next;
  logic [3:0]      bit_cnt_reg, bit_cnt_next;
  logic            sh_reg,      sh_next;
  logic            sdi_reg,     sdi_next;

  logic            timer_zero;
  logic [3:0]      bit_cnt_inc;

  assign timer_zero  = (timer_reg == '0);
  assign bit_cnt_inc = bit_cnt_reg + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      sh_reg      <= 1'b0;
      sdi_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      sh_reg      <= sh_next;
      sdi_reg     <= sdi_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    sh_next      = 1'b0;
    sdi_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          timer_next = HALF_LOAD;
          state_next = VERIFY;
        end
      end

      VERIFY: begin
        if (timer_zero) begin
          if (rx_s) begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            state_next = IDLE;
          end else begin
            // Start bit confirmed; it is shifted in too so that ten shifts
            // always overwrite the whole frame register.
            sh_next      = 1'b1;
            sdi_next     = 1'b0;
            bit_cnt_next = 4'd1;
            timer_next   = FULL_LOAD;
            state_next   = SHIFT;
          end
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      SHIFT: begin
        if (timer_zero) begin
          sh_next      = 1'b1;
          sdi_next     = rx_s;
          bit_cnt_next = bit_cnt_inc;
          if (bit_cnt_inc == FRAME_BITS) begin
            state_next = SETTLE;
          end else begin
            timer_next = FULL_LOAD;
          end
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      // The last sh pulse is visible this cycle; the frame register absorbs it
      // at the end of this cycle, so shiftout is only complete in DONE.
      SETTLE: begin
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame unpack and status
  // ---------------------------------------------------------------------------
  logic       frame_done;
  logic [7:0] data_reg;
  logic       rdy_reg;
  logic       ferr_reg;

  assign frame_done = (state_reg == DONE);

  // A completing frame takes priority over an acknowledge in the same cycle,
  // so a byte is never lost to a late rd_ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      rdy_reg  <= 1'b0;
      ferr_reg <= 1'b0;
    end else if (frame_done) begin
      data_reg <= shiftout[8:1];
      ferr_reg <= ~shiftout[9];
      rdy_reg  <= 1'b1;
    end else if (rd_ack) begin
      rdy_reg  <= 1'b0;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  logic ovr_reg;

  // ovr can only be set while rdy is set, and both are cleared by the same
  // acknowledge, so ovr never outlives the byte it refers to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_reg <= 1'b0;
    end else if (frame_done && rdy_reg && !rd_ack) begin
      ovr_reg <= 1'b1;
    end else if (rd_ack && rdy_reg) begin
      ovr_reg <= 1'b0;
    end
  end

  assign ovr = ovr_reg;
`else
  assign ovr = 1'b0;
`endif

  // The start bit in shiftout[0] was already qualified in VERIFY.
  logic unused_start_bit;
  assign unused_start_bit = shiftout[0];

  assign sh   = sh_reg;
  assign sdi  = sdi_reg;
  assign data = data_reg;
  assign rdy  = rdy_reg;
  assign ferr = ferr_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Self-checking bench for uart_rx_ctrl with BAUD_DIV = 16. The bench supplies
// the 10-bit right-shifting frame register, drives serial frames on rx, and
// checks every sh pulse (cycle and sdi value), the unpacked byte, ferr, rdy
// timing, ovr and busy against expectations computed from the frame timing
// rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int B = 16;
  localparam int H = B / 2 - 1;

`ifdef UART_RX_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic [9:0] frame_reg = '0;
  logic       sh, sdi, rdy, ferr, ovr, busy;
  logic [7:0] data;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .shiftout (frame_reg),
    .rd_ack   (rd_ack),
    .sh       (sh),
    .sdi      (sdi),
    .data     (data),
    .rdy      (rdy),
    .ferr     (ferr),
    .ovr      (ovr),
    .busy     (busy)
  );

  // External frame register: serial in at bit 9, shifts right on sh.
  always @(posedge clk) begin
    if (sh) frame_reg <= {sdi, frame_reg[9:1]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge.
  int   sh_cyc_q[$];
  logic sh_d_q[$];
  int   rise_cyc = -1;
  logic rdy_q = 1'b0;
  int   busy_cnt = 0;

  always @(negedge clk) begin
    if (sh === 1'b1) begin
      sh_cyc_q.push_back(cyc);
      sh_d_q.push_back(sdi);
    end
    if (rdy === 1'b1 && rdy_q !== 1'b1) rise_cyc <= cyc;
    rdy_q <= rdy;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, stop, B clocks each. e is the cycle
  // number of the edge after which rx first goes low; base is the log index
  // where this frame's pulses begin. abort_sh > 0 returns early once that
  // many pulses have been seen.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_sh,
                            output int e, output int base);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    base = sh_cyc_q.size();
    e = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < B; c++) begin
        @(posedge clk);
        #1;
        if (i == 0 && c == 0) e = cyc;
        if (abort_sh > 0 && (sh_cyc_q.size() - base) >= abort_sh) return;
        rx = bits[i];
      end
    end
  endtask

  // Reference: start sample at VERIFY entry (e+3) + H, bit n n*B later,
  // each pulse visible the following cycle.
  task automatic check_pulses(input string name, input logic [7:0] b, input logic stop,
                              input int e, input int base, input int last);
    int got;
    got = last - base;
    check({name, "_sh_count"}, got, 10);
    for (int n = 0; n < 10 && n < got; n++) begin
      logic exp_bit;
      if (n == 0)      exp_bit = 1'b0;
      else if (n == 9) exp_bit = stop;
      else             exp_bit = b[n-1];
      check({name, "_sh_cycle"}, sh_cyc_q[base+n], e + H + 4 + n * B);
      check({name, "_sdi"}, {31'd0, sh_d_q[base+n]}, {31'd0, exp_bit});
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] exp_data,
                              input logic exp_ferr, input int e, input logic do_rise);
    check({name, "_data"}, data, exp_data);
    check({name, "_ferr"}, ferr, exp_ferr);
    check({name, "_rdy"}, rdy, 1'b1);
    // rdy is visible 3 clocks after the stop-bit sample.
    if (do_rise) check({name, "_rdy_time"}, rise_cyc, e + H + 3 + 9 * B + 3);
  endtask

  task automatic ack();
    @(posedge clk);
    #1;
    rd_ack = 1'b1;
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    check("ack_rdy", rdy, 1'b0);
    check("ack_ovr", ovr, 1'b0);
  endtask

  task automatic wait_rdy(input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   e, base, e2, base2, b0;
    logic ok;
    logic [7:0] rb;
    logic rstop;
    vec_t tbl[5];

    tbl[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    tbl[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h80, 1'b0, 8'h80, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sh", sh, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_rdy", rdy, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2 * B);

    // Table-driven frames, each acknowledged
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, 0, e, base);
      idle(2 * B);
      check_pulses("tbl", tbl[i].b, tbl[i].stop, e, base, sh_cyc_q.size());
      check_result("tbl", tbl[i].exp_data, tbl[i].exp_ferr, e, 1'b1);
      ack();
    end

    // 4-clock glitch: VERIFY for H+1 cycles, no pulses, no byte
    b0 = busy_cnt;
    base = sh_cyc_q.size();
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * B) @(posedge clk);
    #1;
    check("glitch_busy_cycles", busy_cnt - b0, H + 1);
    check("glitch_sh_count", sh_cyc_q.size() - base, 0);
    check("glitch_rdy", rdy, 1'b0);
    check("glitch_busy", busy, 1'b0);

    // Two frames without acknowledge
    send_frame(8'h12, 1'b1, 0, e, base);
    idle(2 * B);
    send_frame(8'h34, 1'b1, 0, e, base);
    idle(2 * B);
    check_pulses("ovr", 8'h34, 1'b1, e, base, sh_cyc_q.size());
    check_result("ovr", 8'h34, 1'b0, e, 1'b0);
    check("ovr_flag", ovr, EXP_OVR);
    ack();

    // rd_ack in the DONE cycle: set wins
    fork
      send_frame(8'h5A, 1'b1, 0, e, base);
      begin
        @(posedge clk);
        repeat (H + 5 + 9 * B) @(posedge clk);
        #1;
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
      end
    join
    idle(2 * B);
    check_result("collide", 8'h5A, 1'b0, e, 1'b1);

    // Asynchronous reset after the 5th pulse of a frame
    send_frame(8'hE7, 1'b1, 5, e, base);
    check("rst_mid_pulses", sh_cyc_q.size() - base, 5);
    reset = 1'b1;
    #1;
    check("rst_mid_sh", sh, 1'b0);
    check("rst_mid_sdi", sdi, 1'b0);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_rdy", rdy, 1'b0);
    check("rst_mid_ferr", ferr, 1'b0);
    check("rst_mid_ovr", ovr, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2 * B);
    send_frame(8'hC9, 1'b1, 0, e, base);
    idle(2 * B);
    check_pulses("after_rst", 8'hC9, 1'b1, e, base, sh_cyc_q.size());
    check_result("after_rst", 8'hC9, 1'b0, e, 1'b1);
    ack();

    // Back-to-back 0xFF, 0x00 with a single stop bit, acked in between
    fork
      begin
        send_frame(8'hFF, 1'b1, 0, e, base);
        send_frame(8'h00, 1'b1, 0, e2, base2);
        rx = 1'b1;
      end
      begin
        wait_rdy(400, ok);
        check("b2b_wait1", ok, 1'b1);
        check("b2b_data1", data, 8'hFF);
        check("b2b_ferr1", ferr, 1'b0);
        ack();
        wait_rdy(400, ok);
        check("b2b_wait2", ok, 1'b1);
        check("b2b_data2", data, 8'h00);
        check("b2b_ferr2", ferr, 1'b0);
      end
    join
    idle(2 * B);
    check_pulses("b2b1", 8'hFF, 1'b1, e, base, base2);
    check_pulses("b2b2", 8'h00, 1'b1, e2, base2, sh_cyc_q.size());
    check("b2b_rdy_time", rise_cyc, e2 + H + 6 + 9 * B);
    ack();

    // Randomized frames against the timing model
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(1, 3 * B));
      rb = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(rb, rstop, 0, e, base);
      idle(2 * B);
      check_pulses("rnd", rb, rstop, e, base, sh_cyc_q.size());
      check_result("rnd", rb, ~rstop, e, 1'b1);
      ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receive engine's 10-bit right-shifting frame register (serial in at bit 9, one shift per `sh` pulse). It synchronizes the serial line, detects and qualifies the start bit, and times mid-bit samples. For each of the 10 frame bits (start, 8 data LSB-first, stop) it issues one `sh` pulse with the sampled `sdi`. It then unpacks the captured frame into a data byte with ready, framing-error and (optional) overrun status.

## Interface
- `BAUD_DIV`, default 5208 — clocks per bit period; legal range ≥ 4; bit-timer width is `$clog2(BAUD_DIV)`.
- `clk` input 1 — clock, all logic on rising edge.
- `reset` input 1 — asynchronous, active-high; clock `clk`.
- `rx` input 1 — raw serial line, asynchronous, idle high.
- `shiftout` input 10 — frame register contents, fed back from the shift register.
- `rd_ack` input 1 — single-cycle pulse from consumer; clears `rdy` (and `ovr`).
- `sh` output 1 — registered shift-enable pulse to the frame register, one clock wide.
- `sdi` output 1 — registered sampled bit, valid while `sh`=1.
- `data` output 8 — received byte, held until the next frame completes.
- `rdy` output 1 — byte available; sticky until `rd_ack`.
- `ferr` output 1 — stop bit of the last frame was 0; updated with each frame.
- `ovr` output 1 — overrun flag (see Configuration).
- `busy` output 1 — high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`); both flops reset to 1.
- FSM states: IDLE, VERIFY, SHIFT, SETTLE, DONE.
- IDLE:
  - when `rx_s`=0: load bit timer with `BAUD_DIV/2 - 1` (integer divide); go to VERIFY.
- VERIFY: when the timer reaches 0, sample `rx_s`:
  - 1: false start; return to IDLE with no `sh` pulse.
  - 0: `sh`<=1, `sdi`<=0; bit_cnt<=1; timer<=`BAUD_DIV-1`; go to SHIFT.
- SHIFT: timer counts down; at 0:
  - `sh`<=1, `sdi`<=`rx_s`; bit_cnt increments.
  - If the new bit_cnt=10, go to SETTLE; else reload the timer with `BAUD_DIV-1`.
- SETTLE: one cycle, letting the frame register absorb the final shift; go to DONE.
- DONE: one cycle.
  - `data`<=`shiftout[8:1]`, `ferr`<=~`shiftout[9]`, `rdy`<=1.
  - Go to IDLE. A line still low (break) re-triggers VERIFY from IDLE.
- `sh` is 0 in every cycle not listed above. Exactly 10 pulses per accepted frame, none for a false start.
- `rd_ack` with `rdy`=0 has no effect. `rd_ack` in the same cycle as the DONE set: set wins, `rdy` stays 1.
- `shiftout[0]` (start bit) is not checked; it is qualified in VERIFY.
- Reset, including mid-frame:
  - State to IDLE; timer and bit_cnt to 0.
  - `sh`, `sdi`, `data`, `rdy`, `ferr`, `ovr`, `busy` all 0.
  - A partial frame is discarded; the frame register needs no clearing because 10 shifts fully overwrite it.

## Timing
- `rx` falling edge → `rx_s` low 2 clocks later → VERIFY the following cycle.
- Let T0 be the cycle VERIFY is entered.
  - Start bit sampled at T0 + `BAUD_DIV/2 - 1`.
  - Frame bit n (n=1..9) sampled `n*BAUD_DIV` clocks after the start sample.
- `sh` is visible the cycle after each sample; `shiftout` updates one cycle after that.
- `rdy`/`data`/`ferr` become visible 3 clocks after the stop-bit sample cycle.
- `busy` is high from VERIFY entry through the DONE cycle.
- Back-to-back frames, where the next start edge falls half a bit after the stop sample, are received without loss.

## Configuration
- `UART_RX_OVERRUN_EN` defined:
  - If DONE occurs while `rdy` is already 1 and no `rd_ack` arrives that cycle, `ovr`<=1.
  - `data` is overwritten with the new byte.
  - `ovr` is sticky and cleared only by `rd_ack` or reset.
- Undefined: `ovr` is tied to 0 and no overrun logic is synthesized; `data` is still overwritten silently.

## Test plan
All scenarios use `BAUD_DIV`=16.
- Frame 0x55 with a valid stop bit:
  - Exactly 10 `sh` pulses with `sdi` sequence 0,1,0,1,0,1,0,1,0,1.
  - `data`=0x55, `ferr`=0, `rdy` rises 3 clocks after the stop sample.
  - `rd_ack` drops `rdy`.
- `rx` low glitch of 4 clocks from idle → VERIFY entered, no `sh` pulse, returns to IDLE, `rdy` stays 0.
- Frame 0xA3 with stop bit 0 → `data`=0xA3, `ferr`=1, `rdy`=1.
- Two consecutive frames 0x12 then 0x34 with no `rd_ack`:
  - With `UART_RX_OVERRUN_EN`: `data`=0x34, `ovr`=1.
  - Without the macro: `ovr`=0.
  - In both cases `rd_ack` clears `rdy` and `ovr`.
- `reset` asserted after the 5th `sh` pulse of a frame:
  - All outputs 0 immediately.
  - A following frame 0xC9 is received correctly with exactly 10 pulses.
- Back-to-back frames 0xFF, 0x00 with a 1-bit stop and an immediate next start → both bytes delivered, each acknowledged between frames, `ferr`=0 on both.
